mysystem_hps_to_fpga_cmd: RTL and testbench
===========================================

Name: mysystem_hps_to_fpga_cmd

Overview:
- Avalon-MM slave that carries control from the HPS into FPGA fabric. It is the opposite direction of the fpga_to_hps input PIO.
- Provides a level output register with set/clear aliases.
- Provides a one-shot strobe of programmable length.
- Provides a single-entry command mailbox with a valid/ready handshake to fabric logic, plus sticky status bits readable by software.

Parameters:
- WIDTH, 16, width of out_port, cmd_data and the data fields of the DATA/CMD registers.
- RESET_VALUE, 0, reset value of the DATA register and out_port.
- DEFAULT_PULSE, 4, reset value of PULSE_LEN (8-bit).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write; write strobe = chipselect && !write_n.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  level outputs, equal to the DATA register.
- strobe_out  out  1  one-shot pulse output.
- cmd_data  out  WIDTH  mailbox payload, stable while cmd_valid is high.
- cmd_valid  out  1  mailbox holds an unaccepted command.
- cmd_ready  in  1  fabric accepts the command when cmd_valid && cmd_ready.

Behaviour:
- Register map:
  - 0 DATA: RW.
  - 1 STATUS: RO/W1C. bit0 busy (=cmd_valid), bit1 done (sticky), bit2 overrun (sticky); other bits read 0.
  - 2 PULSE_LEN: RW, bits[7:0].
  - 3 CMD: W launches a command; R returns the last cmd_data.
  - 4 OUTSET: W only; DATA |= writedata[WIDTH-1:0].
  - 5 OUTCLEAR: W only; DATA &= ~writedata[WIDTH-1:0].
  - 6 STROBE: W, any value, fires strobe_out.
  - 7: reserved, reads 0.
  - Write-only addresses (4, 5, 6) read 0.
- Reads:
  - readdata is updated every clock from address alone, independent of chipselect, giving 1-cycle latency.
  - Unused upper bits are zero-extended.
- Reset values:
  - readdata = 0.
  - DATA/out_port = RESET_VALUE.
  - PULSE_LEN = DEFAULT_PULSE.
  - cmd_data = 0, cmd_valid = 0, strobe_out = 0.
  - done = 0, overrun = 0, strobe counter = 0.
  - Reset asserted mid-command or mid-pulse drops cmd_valid and strobe_out on the next edge with no acceptance; done is not set.
- DATA: a write to address 0 updates out_port on the next edge (1-cycle latency).
- Strobe:
  - A write to address 6 loads the counter with max(PULSE_LEN, 1).
  - strobe_out = (counter != 0); the counter decrements each cycle while nonzero.
  - The pulse starts the cycle after the write and lasts exactly max(PULSE_LEN, 1) cycles.
  - A write during an active pulse reloads the counter (retrigger, pulse extended, no gap).
  - A PULSE_LEN write during a pulse affects only the next trigger.
- Mailbox states:
  - IDLE (cmd_valid=0), PENDING (cmd_valid=1).
  - IDLE + CMD write -> PENDING; cmd_data = writedata[WIDTH-1:0] on the next edge.
  - PENDING + cmd_ready -> IDLE; done set.
  - PENDING + CMD write without cmd_ready -> the write is dropped; cmd_data is unchanged; overrun is set; state stays PENDING.
  - PENDING + CMD write with cmd_ready in the same cycle -> the old command is accepted (done set), the new command is loaded, and the state stays PENDING; overrun is not set.
  - cmd_valid never deasserts without acceptance except on reset; cmd_data is never changed while PENDING without acceptance.
- STATUS write:
  - Writing 1 to bit1/bit2 clears done/overrun; bit0 is ignored.
  - A same-cycle set event wins over clear.
- All writes with chipselect=0 are ignored.

Test Plan:
- Reset, then read all 8 addresses -> DATA=RESET_VALUE, STATUS=0, PULSE_LEN=4, others 0; out_port=0, cmd_valid=0, strobe_out=0.
- Write DATA=0x00F0, OUTSET 0x0003, OUTCLEAR 0x0010 -> out_port goes 0x00F0, then 0x00F3, then 0x00E3, each the cycle after its write; DATA readback = 0x00E3.
- PULSE_LEN=3, write STROBE -> strobe_out high exactly 3 cycles. PULSE_LEN=0, write STROBE -> 1 cycle. PULSE_LEN=5, STROBE, then a 2nd STROBE 2 cycles later -> one contiguous 7-cycle pulse.
- CMD=0x1234 with cmd_ready=0 for 5 cycles -> cmd_valid held, cmd_data=0x1234, STATUS=0x1. Raise cmd_ready for 1 cycle -> cmd_valid drops, STATUS=0x2. Write STATUS 0x2 -> STATUS=0.
- CMD=0xAAAA pending, CMD=0x5555 with cmd_ready=0 -> cmd_data stays 0xAAAA, STATUS=0x5. Then CMD=0x7777 in the same cycle as cmd_ready=1 -> 0xAAAA accepted, cmd_data=0x7777, cmd_valid stays 1, STATUS=0x7.
- Assert reset for 1 cycle mid-pulse with a command pending -> strobe_out=0, cmd_valid=0, STATUS=0, DATA=RESET_VALUE on the next edge.

Source files
------------

// File: rtl/mysystem_hps_to_fpga_cmd_if.sv
// Avalon-MM slave bus plus the fabric-side command handshake of the HPS-to-FPGA
// command block. cmd_ready is driven by the fabric consumer, which shares the master side.
interface mysystem_hps_to_fpga_cmd_if #(
    parameter int WIDTH = 16
);
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_valid;
    logic             cmd_ready;

    modport slave (
        input  address, chipselect, write_n, writedata, cmd_ready,
        output readdata, cmd_data, cmd_valid
    );

    modport master (
        output address, chipselect, write_n, writedata, cmd_ready,
        input  readdata, cmd_data, cmd_valid
    );
endinterface

// File: rtl/mysystem_hps_to_fpga_cmd.sv
// HPS-to-FPGA control: level output register with set/clear aliases, retriggerable
// one-shot strobe, and a single-entry command mailbox with sticky done/overrun status.
module mysystem_hps_to_fpga_cmd #(
    parameter int               WIDTH         = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter logic [7:0]       DEFAULT_PULSE = 8'd4
) (
    input  logic                         clk,
    input  logic                         reset,
    mysystem_hps_to_fpga_cmd_if.slave    bus,
    output logic [WIDTH-1:0]             out_port,
    output logic                         strobe_out
);
    typedef enum logic {S_IDLE, S_PENDING} mbox_state_t;

    mbox_state_t      r_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_cmd_data;
    logic             r_cmd_valid;
    logic             r_done;
    logic             r_overrun;
    logic [7:0]       r_pulse_len;
    logic [7:0]       r_cnt;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic             w_accept;
    logic             w_cmd_wr;
    logic             w_stat_wr;
    logic [31:0]      w_rd_next;
    logic             w_unused;

    assign w_wr      = bus.chipselect && !bus.write_n;
    assign w_cmd_wr  = w_wr && (bus.address == 3'd3);
    assign w_stat_wr = w_wr && (bus.address == 3'd1);
    assign w_accept  = r_cmd_valid && bus.cmd_ready;
    assign w_unused  = ^bus.writedata;

    assign out_port      = r_data;
    assign strobe_out    = (r_cnt != 8'd0);
    assign bus.cmd_data  = r_cmd_data;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.readdata  = r_readdata;

    always_comb begin
        w_rd_next = 32'd0;
        case (bus.address)
            3'd0:    w_rd_next = 32'(r_data);
            3'd1:    w_rd_next = {29'd0, r_overrun, r_done, r_cmd_valid};
            3'd2:    w_rd_next = {24'd0, r_pulse_len};
            3'd3:    w_rd_next = 32'(r_cmd_data);
            default: w_rd_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata  <= 32'd0;
            r_data      <= RESET_VALUE;
            r_pulse_len <= DEFAULT_PULSE;
            r_cnt       <= 8'd0;
        end else begin
            r_readdata <= w_rd_next;
            if (w_wr && bus.address == 3'd0)
                r_data <= bus.writedata[WIDTH-1:0];
            else if (w_wr && bus.address == 3'd4)
                r_data <= r_data | bus.writedata[WIDTH-1:0];
            else if (w_wr && bus.address == 3'd5)
                r_data <= r_data & ~bus.writedata[WIDTH-1:0];
            if (w_wr && bus.address == 3'd2)
                r_pulse_len <= bus.writedata[7:0];
            // A trigger reloads the counter even mid-pulse, so retriggers extend without a gap.
            if (w_wr && bus.address == 3'd6)
                r_cnt <= (r_pulse_len == 8'd0) ? 8'd1 : r_pulse_len;
            else if (r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
        end
    end

    // Mailbox FSM; status set events are applied after clears so a set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_data  <= '0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done    <= w_accept | (r_done & ~(w_stat_wr & bus.writedata[1]));
            r_overrun <= (w_cmd_wr && r_cmd_valid && !bus.cmd_ready)
                       | (r_overrun & ~(w_stat_wr & bus.writedata[2]));
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_wr) begin
                        r_state     <= S_PENDING;
                        r_cmd_valid <= 1'b1;
                        r_cmd_data  <= bus.writedata[WIDTH-1:0];
                    end
                end
                S_PENDING: begin
                    if (bus.cmd_ready) begin
                        if (w_cmd_wr) begin
                            r_cmd_data <= bus.writedata[WIDTH-1:0];
                        end else begin
                            r_state     <= S_IDLE;
                            r_cmd_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mysystem_hps_to_fpga_cmd.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level reference model of the register map, strobe window and mailbox.
module tb_mysystem_hps_to_fpga_cmd;
    localparam int         W  = 16;
    localparam logic [W-1:0] RV = 16'h0000;

    logic clk = 1'b0;
    logic reset;
    logic [W-1:0] out_port;
    logic strobe_out;

    always #5 clk = ~clk;

    mysystem_hps_to_fpga_cmd_if #(.WIDTH(W)) bus ();

    mysystem_hps_to_fpga_cmd #(
        .WIDTH(W), .RESET_VALUE(RV), .DEFAULT_PULSE(8'd4)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .out_port(out_port), .strobe_out(strobe_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: strobe is a time window [write edge, m_end) in edge counts.
    logic [W-1:0] m_data, m_cmd;
    logic [7:0]   m_pulse;
    logic         m_pend, m_done, m_ovr;
    logic [31:0]  m_rd;
    int           m_e = 0;
    int           m_end = 0;

    function automatic logic m_strobe();
        return (m_e < m_end);
    endfunction

    task automatic step();
        logic r, w, rdy, acc, cw;
        logic [2:0] a;
        logic [31:0] wd, rd;
        r = reset; w = bus.chipselect && !bus.write_n; a = bus.address;
        wd = bus.writedata; rdy = bus.cmd_ready;
        case (a)
            3'd0:    rd = {16'd0, m_data};
            3'd1:    rd = {29'd0, m_ovr, m_done, m_pend};
            3'd2:    rd = {24'd0, m_pulse};
            3'd3:    rd = {16'd0, m_cmd};
            default: rd = 32'd0;
        endcase
        @(posedge clk);
        m_e++;
        if (r) begin
            m_rd = 0; m_data = RV; m_pulse = 8'd4; m_cmd = '0;
            m_pend = 0; m_done = 0; m_ovr = 0; m_end = 0;
        end else begin
            m_rd = rd;
            acc = m_pend && rdy;
            cw  = w && (a == 3'd3);
            if (w && a == 3'd1) begin
                if (wd[1]) m_done = 0;
                if (wd[2]) m_ovr = 0;
            end
            if (acc) m_done = 1;
            if (cw && m_pend && !rdy) m_ovr = 1;
            if (cw && (!m_pend || acc)) begin
                m_cmd = wd[W-1:0]; m_pend = 1;
            end else if (acc) begin
                m_pend = 0;
            end
            if (w) begin
                case (a)
                    3'd0: m_data = wd[W-1:0];
                    3'd2: m_pulse = wd[7:0];
                    3'd4: m_data = m_data | wd[W-1:0];
                    3'd5: m_data = m_data & ~wd[W-1:0];
                    3'd6: m_end = m_e + ((m_pulse == 0) ? 1 : int'(m_pulse));
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1; bus.write_n = 0;
        step();
        bus.chipselect = 0; bus.write_n = 1;
    endtask

    task automatic rd(input logic [2:0] a);
        bus.address = a;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        reset = 1; step(); step(); reset = 0;
        checks++;
        if ({out_port, strobe_out, bus.cmd_valid} !== {RV, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h strobe=%b valid=%b", out_port, strobe_out, bus.cmd_valid);
        end
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            exp = (a == 0) ? {16'd0, RV} : (a == 2) ? 32'd4 : 32'd0;
            checks++;
            if (bus.readdata !== exp) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h expected %h", a, bus.readdata, exp);
            end
        end
    endtask

    task automatic test_data();
        logic [W-1:0] seq [3];
        seq = '{16'h00F0, 16'h00F3, 16'h00E3};
        wr(0, 32'h00F0);
        checks++; if (out_port !== seq[0]) begin errors++; $display("FAIL data_write: got %h expected %h", out_port, seq[0]); end
        wr(4, 32'h0003);
        checks++; if (out_port !== seq[1]) begin errors++; $display("FAIL data_set: got %h expected %h", out_port, seq[1]); end
        wr(5, 32'h0010);
        checks++; if (out_port !== seq[2]) begin errors++; $display("FAIL data_clear: got %h expected %h", out_port, seq[2]); end
        rd(0);
        checks++; if (bus.readdata !== 32'h00E3) begin errors++; $display("FAIL data_readback: got %h expected 000000e3", bus.readdata); end
        // chipselect low must block a write
        bus.address = 0; bus.writedata = 32'hFFFF; bus.chipselect = 0; bus.write_n = 0;
        step(); bus.write_n = 1;
        checks++; if (out_port !== 16'h00E3) begin errors++; $display("FAIL data_no_cs: got %h expected 00e3", out_port); end
        for (int i = 0; i < 6; i++) begin
            wr(3'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(4, 5)), $urandom);
            checks++;
            if (out_port !== m_data) begin errors++; $display("FAIL data_rand[%0d]: got %h expected %h", i, out_port, m_data); end
        end
    endtask

    task automatic test_strobe();
        int lens [4];
        int exp_n [4];
        int n; bit fell, gap;
        lens = '{3, 0, 5, 0};
        exp_n = '{3, 1, 7, 0};
        lens[3] = $urandom_range(1, 20);
        exp_n[3] = lens[3];
        for (int t = 0; t < 4; t++) begin
            wr(2, 32'(lens[t]));
            checks++;
            if (strobe_out !== 1'b0) begin errors++; $display("FAIL strobe_idle[%0d]: got %b expected 0", t, strobe_out); end
            wr(6, $urandom);
            n = 0; fell = 0; gap = 0;
            for (int c = 0; c < 30; c++) begin
                if (strobe_out) begin if (fell) gap = 1; n++; end
                else if (n > 0) fell = 1;
                checks++;
                if (strobe_out !== m_strobe()) begin errors++; $display("FAIL strobe_model[%0d] cycle %0d: got %b expected %b", t, c, strobe_out, m_strobe()); end
                if (t == 2 && c == 1) wr(6, 0);
                else step();
            end
            checks++;
            if (n !== exp_n[t] || gap) begin errors++; $display("FAIL strobe_len[%0d]: got %0d cycles gap=%b expected %0d contiguous", t, n, gap, exp_n[t]); end
        end
    endtask

    task automatic test_mailbox();
        bus.cmd_ready = 0;
        wr(3, 32'h1234);
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({bus.cmd_valid, bus.cmd_data} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL cmd_hold[%0d]: got valid=%b data=%h expected 1/1234", c, bus.cmd_valid, bus.cmd_data); end
        end
        rd(1);
        checks++; if (bus.readdata !== 32'h1) begin errors++; $display("FAIL status_busy: got %h expected 1", bus.readdata); end
        bus.cmd_ready = 1; step(); bus.cmd_ready = 0;
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL cmd_accept: got valid=%b expected 0", bus.cmd_valid); end
        rd(1);
        checks++; if (bus.readdata !== 32'h2) begin errors++; $display("FAIL status_done: got %h expected 2", bus.readdata); end
        wr(1, 32'h2); rd(1);
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL status_w1c: got %h expected 0", bus.readdata); end
    endtask

    task automatic test_overrun();
        bus.cmd_ready = 0;
        wr(3, 32'hAAAA);
        wr(3, 32'h5555);
        checks++; if (bus.cmd_data !== 16'hAAAA) begin errors++; $display("FAIL overrun_keep: got %h expected aaaa", bus.cmd_data); end
        rd(1);
        checks++; if (bus.readdata !== 32'h5) begin errors++; $display("FAIL overrun_status: got %h expected 5", bus.readdata); end
        bus.cmd_ready = 1; wr(3, 32'h7777); bus.cmd_ready = 0;
        checks++;
        if ({bus.cmd_valid, bus.cmd_data} !== {1'b1, 16'h7777}) begin errors++; $display("FAIL accept_load: got valid=%b data=%h expected 1/7777", bus.cmd_valid, bus.cmd_data); end
        rd(1);
        checks++; if (bus.readdata !== 32'h7) begin errors++; $display("FAIL accept_load_status: got %h expected 7", bus.readdata); end
        // clearing done in the same cycle as a new acceptance leaves done set
        bus.cmd_ready = 1; wr(1, 32'h6); bus.cmd_ready = 0;
        rd(1);
        checks++; if (bus.readdata !== 32'h2) begin errors++; $display("FAIL set_wins: got %h expected 2", bus.readdata); end
        wr(1, 32'h6);
    endtask

    task automatic test_reset_mid();
        wr(0, 32'h5A5A);
        wr(2, 32'd10);
        wr(3, 32'hBEEF);
        wr(6, 32'd0);
        step();
        reset = 1; step(); reset = 0;
        checks++;
        if ({strobe_out, bus.cmd_valid, out_port} !== {1'b0, 1'b0, RV}) begin errors++; $display("FAIL reset_mid: got strobe=%b valid=%b out=%h expected 0/0/%h", strobe_out, bus.cmd_valid, out_port, RV); end
        rd(1);
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_mid_status: got %h expected 0", bus.readdata); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.address    = 3'($urandom_range(0, 7));
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.write_n    = $urandom_range(0, 1) == 1;
            bus.writedata  = (bus.address == 3'd2) ? 32'($urandom_range(0, 12)) : $urandom;
            bus.cmd_ready  = ($urandom_range(0, 3) == 0);
            step();
            checks++;
            if ({bus.readdata, out_port, strobe_out, bus.cmd_valid, bus.cmd_data} !==
                {m_rd, m_data, m_strobe(), m_pend, m_cmd}) begin
                errors++;
                $display("FAIL random[%0d]: got rd=%h out=%h stb=%b v=%b cmd=%h expected rd=%h out=%h stb=%b v=%b cmd=%h",
                         c, bus.readdata, out_port, strobe_out, bus.cmd_valid, bus.cmd_data,
                         m_rd, m_data, m_strobe(), m_pend, m_cmd);
            end
        end
        bus.chipselect = 0; bus.write_n = 1; bus.cmd_ready = 0;
    endtask

    initial begin
        reset = 1;
        bus.address = 0; bus.chipselect = 0; bus.write_n = 1;
        bus.writedata = 0; bus.cmd_ready = 0;
        test_reset();
        test_data();
        test_strobe();
        test_mailbox();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
